// File: rtl/lsm_pkg.sv
// Shared definitions for the LSM accumulator machine: opcode values, instruction
// field positions and the sequencer state encoding. Also used by EPROM models and
// program-image generators so that instruction encoding lives in one place.
package lsm_pkg;

  // Instruction layout: {op[7:6], addr[5:2], unused[1:0]}
  localparam int unsigned OP_MSB   = 7;
  localparam int unsigned OP_LSB   = 6;
  localparam int unsigned ADDR_MSB = 5;
  localparam int unsigned ADDR_LSB = 2;

  localparam logic [1:0] OP_IN  = 2'b00;
  localparam logic [1:0] OP_OUT = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_LDA = 2'b11;

  typedef enum logic [2:0] {
    StFetchA,
    StFetchB,
    StExec,
    StInWait,
    StOutWait,
    StLdaWait
  } state_e;

  // Builds one instruction byte; unused low bits are left at zero.
  function automatic logic [7:0] make_insn(input logic [1:0] op, input logic [3:0] addr);
    logic [7:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]     = op;
    w[ADDR_MSB:ADDR_LSB] = addr;
    return w;
  endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Bus bundle between the LSM sequencer and its surroundings.
//   rom_*     : program EPROM (address, chip select, read enable, returned byte)
//   ram_*     : data RAM (address, write data, write/read strobes, read data)
//   in_*      : input port valid/ready handshake with data
//   out_*     : output port valid/ready handshake with data
//   pc_o      : debug view of the program counter
// master = sequencer side, slave = memories/ports side.
interface lsm_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();

  logic [ADDR_W-1:0] rom_ar;
  logic              rom_cs;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_dr;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  logic [ADDR_W-1:0] pc_o;

  modport master (
    output rom_ar, rom_cs, rom_rd,
    input  rom_dr,
    output ram_addr, ram_wdata, ram_we, ram_rd,
    input  ram_rdata,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output pc_o
  );

  modport slave (
    input  rom_ar, rom_cs, rom_rd,
    output rom_dr,
    input  ram_addr, ram_wdata, ram_we, ram_rd,
    output ram_rdata,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  pc_o
  );

endinterface

// File: rtl/lsm_sequencer.sv
// Fetch/decode/execute control unit of the LSM accumulator machine.
// Owns PC, IR and ACC; fetches a byte from the EPROM in two cycles, then executes
// IN / OUT / STA / LDA against the input port, output port and data RAM.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lsm_sequencer_if.master (EPROM, RAM, in/out ports, debug PC)
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OP_W   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  lsm_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  logic [OP_W-1:0]   op;
  logic              unused_ir_bits;

  assign op             = ir_q[DATA_W-1 -: OP_W];
  assign unused_ir_bits = ^ir_q[DATA_W-OP_W-ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    unique case (state_q)
      StFetchA: state_d = StFetchB;
      StFetchB: begin
        ir_d    = bus.rom_dr;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = StExec;
      end
      StExec: begin
        case (op)
          OP_IN:   state_d = StInWait;
          OP_OUT:  state_d = StOutWait;
          OP_STA:  state_d = StFetchA;
          OP_LDA:  state_d = StLdaWait;
          default: state_d = StFetchA;
        endcase
      end
      StInWait: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_data;
          state_d = StFetchA;
        end
      end
      StOutWait: begin
        if (bus.out_ready) state_d = StFetchA;
      end
      StLdaWait: begin
        acc_d   = bus.ram_rdata;
        state_d = StFetchA;
      end
      default: state_d = StFetchA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetchA;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
    end
  end

  // Strobes are decoded from the state register and qualified with rst_n so they
  // drop the moment reset asserts, even though the reset state is StFetchA.
  always_comb begin
    bus.rom_cs    = rst_n && (state_q == StFetchA || state_q == StFetchB);
    bus.rom_rd    = rst_n && (state_q == StFetchA || state_q == StFetchB);
    bus.ram_we    = rst_n && (state_q == StExec) && (op == OP_STA);
    bus.ram_rd    = rst_n && (state_q == StExec) && (op == OP_LDA);
    bus.in_ready  = rst_n && (state_q == StInWait);
    bus.out_valid = rst_n && (state_q == StOutWait);
    bus.rom_ar    = pc_q;
    bus.pc_o      = pc_q;
    bus.ram_addr  = ir_q[DATA_W-OP_W-1 -: ADDR_W];
    bus.ram_wdata = acc_q;
    bus.out_data  = acc_q;
  end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Fetch/decode/execute control unit for the LSM accumulator machine.
- Sits directly upstream of the program EPROM: drives its address/cs/rd, captures the returned byte as an instruction, then executes it.
- Owns PC, IR and ACC, plus the data-RAM, input-port and output-port interfaces.
- ISA: {op[7:6], addr[5:2], unused[1:0]}; op IN=00, OUT=01, STA=10, LDA=11.

Parameters:
DATA_W, 8, data/instruction width
ADDR_W, 4, ROM and RAM address width; PC width
OP_W, 2, opcode field width (bits DATA_W-1 .. DATA_W-OP_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rom_ar  output  ADDR_W  EPROM address, always equal to PC
rom_cs  output  1  EPROM chip select
rom_rd  output  1  EPROM read enable
rom_dr  input  DATA_W  EPROM data; registered one cycle after address, high-Z unless cs&rd
ram_addr  output  ADDR_W  data-RAM address = IR[5:2]
ram_wdata  output  DATA_W  = ACC
ram_we  output  1  RAM write strobe, one cycle
ram_rd  output  1  RAM read strobe; ram_rdata valid the following cycle
ram_rdata  input  DATA_W  RAM read data
in_data  input  DATA_W  input-port data
in_valid  input  1  input-port data available
in_ready  output  1  sequencer accepting input
out_data  output  DATA_W  = ACC
out_valid  output  1  output data presented
out_ready  input  1  consumer accepts output
pc_o  output  ADDR_W  current PC (debug)

Behaviour:
- Reset (async, rst_n=0): PC=0, IR=0, ACC=0, state=FETCH_A; rom_cs, rom_rd, ram_we, ram_rd, in_ready, out_valid all 0 immediately. Reset mid-handshake aborts it without completing the transfer; after release, execution restarts at PC=0.
- States: FETCH_A, FETCH_B, EXEC, IN_WAIT, OUT_WAIT, LDA_WAIT.
- FETCH_A: rom_cs=rom_rd=1, rom_ar=PC; EPROM latches mem[PC] at the edge; -> FETCH_B.
- FETCH_B: rom_cs=rom_rd=1, rom_dr is valid; at the edge IR<=rom_dr, PC<=PC+1 (mod 2^ADDR_W; 15 wraps to 0); -> EXEC.
- rom_cs/rom_rd are 0 in every other state; the bus must float.
- EXEC decodes IR[7:6]:
  - IN -> IN_WAIT.
  - OUT -> OUT_WAIT.
  - STA: ram_we=1 this cycle, ram_addr=IR[5:2], ram_wdata=ACC; -> FETCH_A.
  - LDA: ram_rd=1, ram_addr=IR[5:2]; -> LDA_WAIT.
- IN_WAIT: in_ready=1; on in_valid&in_ready, ACC<=in_data and -> FETCH_A; otherwise stay. If in_valid is already high, transfer completes in the first IN_WAIT cycle.
- OUT_WAIT: out_valid=1, out_data=ACC held stable; on out_ready -> FETCH_A; otherwise stay.
- LDA_WAIT: ACC<=ram_rdata; -> FETCH_A.
- Cycle cost per instruction, excluding handshake stalls: STA 3, LDA 4, IN 4, OUT 4.
- Unused bits IR[1:0] are ignored.
- No halt. The program runs forever, with PC wrapping modulo 2^ADDR_W.
- ram_addr is driven from IR at all times. ram_we and ram_rd are never both 1.

Decomposition:
- Shared package lsm_pkg:
  - opcode localparams OP_IN, OP_OUT, OP_STA, OP_LDA (2'b00..2'b11);
  - field positions (OP_MSB/LSB, ADDR_MSB/LSB);
  - state encoding.
- The EPROM and any program-image generator use the same package.
- No sub-module: one flat FSM plus PC/IR/ACC registers. A separate decoder adds only ports.

Test Plan:
- Standard program (IN; STA 5; IN; STA 10; LDA 5; OUT; LDA 10; OUT), in_data 0x3C then 0xA5, in_valid/out_ready held 1 -> out beats 0x3C then 0xA5; RAM[5]=0x3C, RAM[10]=0xA5; first out_valid at cycle 22 after reset release.
- Same program, out_ready held 0 for 5 cycles in first OUT_WAIT -> out_valid=1 with out_data=0x3C stable all 5 cycles; PC stays 6; one beat only.
- in_valid low for 7 cycles in first IN_WAIT -> in_ready=1 throughout; ACC unchanged (0) until the in_valid cycle; rom_cs=0 throughout.
- rst_n pulsed low during the second IN_WAIT -> in_ready drops asynchronously; PC/ACC=0; next fetch has rom_ar=0; RAM[5] keeps 0x3C.
- ROM loaded entirely with IN, in_valid=1 -> PC counts 0..15 then 0; rom_ar tracks PC; rom_cs/rom_rd high only in the two fetch cycles of each instruction.
